// File: rtl/amo_pkg.sv
// Shared types and constants for the AMO read-modify-write sequencer.
package amo_pkg;

    typedef enum logic [2:0] {
        ADD  = 3'd0,
        SWAP = 3'd1,
        LR   = 3'd2,
        SC   = 3'd3
    } amo_funct_e;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        EXEC,
        EXEC_WAIT,
        WR_REQ,
        RESP
    } amo_state_e;

    localparam logic [63:0] SC_FAIL = 64'd1;

endpackage

// File: rtl/amo_resv_tracker.sv
// LR/SC reservation register with match and clear logic.
// Only present when AMO_LRSC_EN is defined; the default build has no reservation.
`ifdef AMO_LRSC_EN
module amo_resv_tracker (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        set,
    input  logic [63:0] set_addr,
    input  logic        sc_clr,
    input  logic        wr_gnt,
    input  logic [63:0] wr_addr,
    input  logic        snoop_valid,
    input  logic [63:0] snoop_addr,
    input  logic [63:0] chk_addr,
    output logic        hit
);
    logic        valid_q;
    logic [63:0] addr_q;
    logic        snoop_hit;
    logic        wr_hit;

    assign snoop_hit = snoop_valid && (snoop_addr == addr_q);
    assign wr_hit    = wr_gnt && (wr_addr == addr_q);
    // A snoop arriving in the same cycle as the SC check makes the SC fail.
    assign hit       = valid_q && (chk_addr == addr_q) && !snoop_hit;

    // An LR load return takes priority over a coincident snoop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
        end else if (set) begin
            valid_q <= 1'b1;
            addr_q  <= set_addr;
        end else if (sc_clr || wr_hit || snoop_hit) begin
            valid_q <= 1'b0;
        end
    end

endmodule
`endif

// File: rtl/amo_seq_ctrl.sv
// RV64A AMO sequencer: read-modify-write over the LSU port via the AMO unit.
// Define AMO_LRSC_EN to add LR.D/SC.D support with a single reservation.
module amo_seq_ctrl #(
    parameter int unsigned TAG_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [63:0]      req_addr_i,
    input  logic [63:0]      req_data_i,
    input  logic [2:0]       req_funct_i,
    input  logic [TAG_W-1:0] req_tag_i,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic [63:0]      mem_addr_o,
    output logic [63:0]      mem_wdata_o,
    input  logic             mem_gnt_i,
    input  logic             mem_rvalid_i,
    input  logic [63:0]      mem_rdata_i,
    output logic             amo_valid_o,
    output logic [63:0]      amo_op_a_o,
    output logic [63:0]      amo_op_b_o,
    output logic [2:0]       amo_funct_o,
    input  logic             amo_ready_i,
    input  logic [63:0]      amo_result_i,
    input  logic             snoop_valid_i,
    input  logic [63:0]      snoop_addr_i,
    output logic             resp_valid_o,
    input  logic             resp_ready_i,
    output logic [63:0]      resp_data_o,
    output logic [TAG_W-1:0] resp_tag_o,
    output logic             resp_err_o
);
    import amo_pkg::*;

    amo_state_e       state_q, state_d;
    logic [63:0]      addr_q;
    logic [63:0]      data_q;
    logic [63:0]      wdata_q;
    logic [63:0]      resp_data_q;
    logic [2:0]       funct_q;
    logic [TAG_W-1:0] tag_q;
    logic             err_q;
    logic             accept;
    logic             funct_bad;
    logic             req_err;
    logic             sc_hit;

    assign accept = (state_q == IDLE) && req_valid_i;

`ifdef AMO_LRSC_EN
    assign funct_bad = req_funct_i[2];

    amo_resv_tracker u_resv (
        .clk         (clk),
        .rst_n       (rst_n),
        .set         (state_q == RD_WAIT && mem_rvalid_i && funct_q == LR),
        .set_addr    (addr_q),
        .sc_clr      (accept && req_funct_i == SC),
        .wr_gnt      (state_q == WR_REQ && mem_gnt_i),
        .wr_addr     (addr_q),
        .snoop_valid (snoop_valid_i),
        .snoop_addr  (snoop_addr_i),
        .chk_addr    (req_addr_i),
        .hit         (sc_hit)
    );
`else
    logic unused_snoop;

    assign funct_bad    = req_funct_i[2] || req_funct_i[1];
    assign sc_hit       = 1'b0;
    assign unused_snoop = ^{snoop_valid_i, snoop_addr_i};
`endif

    assign req_err = (req_addr_i[2:0] != 3'd0) || funct_bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    if (req_err)                  state_d = RESP;
                    else if (req_funct_i == SC)   state_d = sc_hit ? WR_REQ : RESP;
                    else                          state_d = RD_REQ;
                end
            end
            RD_REQ:    if (mem_gnt_i)    state_d = RD_WAIT;
            RD_WAIT:   if (mem_rvalid_i) state_d = (funct_q == LR) ? RESP : EXEC;
            EXEC:                        state_d = EXEC_WAIT;
            EXEC_WAIT: if (amo_ready_i)  state_d = WR_REQ;
            WR_REQ:    if (mem_gnt_i)    state_d = RESP;
            RESP:      if (resp_ready_i) state_d = IDLE;
            default:                     state_d = IDLE;
        endcase
    end

    // resp_data_q doubles as the loaded old value fed to the AMO unit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q      <= '0;
            data_q      <= '0;
            wdata_q     <= '0;
            resp_data_q <= '0;
            funct_q     <= '0;
            tag_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            if (accept) begin
                addr_q      <= req_addr_i;
                data_q      <= req_data_i;
                wdata_q     <= req_data_i;
                funct_q     <= req_funct_i;
                tag_q       <= req_tag_i;
                err_q       <= req_err;
                resp_data_q <= (!req_err && req_funct_i == SC && !sc_hit) ? SC_FAIL : '0;
            end
            if (state_q == RD_WAIT && mem_rvalid_i) resp_data_q <= mem_rdata_i;
            if (state_q == EXEC_WAIT && amo_ready_i) wdata_q <= amo_result_i;
        end
    end

    assign req_ready_o  = (state_q == IDLE);
    assign mem_req_o    = (state_q == RD_REQ) || (state_q == WR_REQ);
    assign mem_we_o     = (state_q == WR_REQ);
    assign mem_addr_o   = addr_q;
    assign mem_wdata_o  = wdata_q;
    assign amo_valid_o  = (state_q == EXEC);
    assign amo_op_a_o   = resp_data_q;
    assign amo_op_b_o   = data_q;
    assign amo_funct_o  = funct_q;
    assign resp_valid_o = (state_q == RESP);
    assign resp_data_o  = resp_data_q;
    assign resp_tag_o   = tag_q;
    assign resp_err_o   = err_q;

endmodule

// File: tb/tb_amo_seq_ctrl.sv
// Randomized self-checking bench for amo_seq_ctrl against a transaction-level model.
module tb_amo_seq_ctrl;
    localparam int unsigned TAG_W = 6;
`ifdef AMO_LRSC_EN
    localparam bit LRSC = 1'b1;
`else
    localparam bit LRSC = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req_valid_i, req_ready_o;
    logic [63:0]      req_addr_i, req_data_i;
    logic [2:0]       req_funct_i;
    logic [TAG_W-1:0] req_tag_i;
    logic             mem_req_o, mem_we_o;
    logic [63:0]      mem_addr_o, mem_wdata_o;
    logic             mem_gnt_i, mem_rvalid_i;
    logic [63:0]      mem_rdata_i;
    logic             amo_valid_o;
    logic [63:0]      amo_op_a_o, amo_op_b_o;
    logic [2:0]       amo_funct_o;
    logic             amo_ready_i;
    logic [63:0]      amo_result_i;
    logic             snoop_valid_i;
    logic [63:0]      snoop_addr_i;
    logic             resp_valid_o, resp_ready_i;
    logic [63:0]      resp_data_o;
    logic [TAG_W-1:0] resp_tag_o;
    logic             resp_err_o;

    always #5 clk = ~clk;

    amo_seq_ctrl #(.TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_addr_i(req_addr_i), .req_data_i(req_data_i),
        .req_funct_i(req_funct_i), .req_tag_i(req_tag_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .amo_valid_o(amo_valid_o), .amo_op_a_o(amo_op_a_o), .amo_op_b_o(amo_op_b_o),
        .amo_funct_o(amo_funct_o), .amo_ready_i(amo_ready_i), .amo_result_i(amo_result_i),
        .snoop_valid_i(snoop_valid_i), .snoop_addr_i(snoop_addr_i),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
        .resp_data_o(resp_data_o), .resp_tag_o(resp_tag_o), .resp_err_o(resp_err_o)
    );

    int unsigned n_cmp = 0;
    int unsigned n_mis = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] init_val(input logic [63:0] a);
        return a * 64'h9E37_79B9_7F4A_7C15 + 64'd3;
    endfunction

    // Environment memory (what the LSU port sees) and the model's own copy.
    logic [63:0] mem[logic [63:0]];
    logic [63:0] ref_mem[logic [63:0]];

    function automatic logic [63:0] env_rd(input logic [63:0] a);
        return mem.exists(a) ? mem[a] : init_val(a);
    endfunction

    function automatic logic [63:0] ref_rd(input logic [63:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    function automatic logic [63:0] outs_or();
        return 64'(|{mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, amo_valid_o, amo_op_a_o,
                     amo_op_b_o, amo_funct_o, resp_valid_o, resp_data_o, resp_tag_o, resp_err_o});
    endfunction

    // Memory port and AMO unit responder, all driven on the falling edge.
    int unsigned gnt_lo = 0, gnt_hi = 0, rv_lo = 0, rv_hi = 0, amo_hi = 0;
    int unsigned n_rd = 0, n_wr = 0;
    logic [127:0] wr_q[$];
    bit          hs_req = 1'b0, hs_we = 1'b0, gnt_armed = 1'b0, rd_pend = 1'b0, amo_pend = 1'b0;
    logic [63:0] hs_addr = '0, hs_wdata = '0, rd_addr = '0, amo_res = '0;
    int unsigned gnt_cnt = 0, rd_cnt = 0, amo_cnt = 0;

    initial begin
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        amo_ready_i = 1'b0; amo_result_i = '0;
        forever begin
            @(negedge clk);
            if (hs_req && mem_gnt_i) begin
                if (hs_we) begin
                    mem[hs_addr] = hs_wdata;
                    wr_q.push_back({hs_addr, hs_wdata});
                    n_wr++;
                end else begin
                    rd_pend = 1'b1; rd_addr = hs_addr;
                    rd_cnt = $urandom_range(rv_hi, rv_lo);
                    n_rd++;
                end
            end else if (hs_req && rst_n) begin
                check_eq("hold_req", 64'({mem_req_o, mem_we_o}), 64'({1'b1, hs_we}));
                check_eq("hold_addr", mem_addr_o, hs_addr);
                check_eq("hold_wdata", mem_wdata_o, hs_wdata);
            end
            mem_rvalid_i = 1'b0;
            if (rd_pend) begin
                if (rd_cnt == 0) begin
                    mem_rvalid_i = 1'b1; mem_rdata_i = env_rd(rd_addr); rd_pend = 1'b0;
                end else rd_cnt--;
            end
            amo_ready_i = 1'b0;
            if (!rst_n) amo_pend = 1'b0;
            if (amo_pend) begin
                if (amo_cnt == 0) begin
                    amo_ready_i = 1'b1; amo_result_i = amo_res; amo_pend = 1'b0;
                end else amo_cnt--;
            end
            if (amo_valid_o) begin
                amo_pend = 1'b1;
                amo_cnt  = $urandom_range(amo_hi, 0);
                amo_res  = (amo_funct_o == 3'd0) ? amo_op_a_o + amo_op_b_o : amo_op_b_o;
            end
            hs_req = mem_req_o; hs_we = mem_we_o; hs_addr = mem_addr_o; hs_wdata = mem_wdata_o;
            mem_gnt_i = 1'b0;
            if (mem_req_o) begin
                if (!gnt_armed) begin
                    gnt_cnt = $urandom_range(gnt_hi, gnt_lo); gnt_armed = 1'b1;
                end
                if (gnt_cnt == 0) begin
                    mem_gnt_i = 1'b1; gnt_armed = 1'b0;
                end else gnt_cnt--;
            end else gnt_armed = 1'b0;
        end
    end

    // Reference model state: reservation as seen by architecture.
    bit          resv_v = 1'b0;
    logic [63:0] resv_a = '0;

    task automatic do_op(input logic [2:0] f, input logic [63:0] a, input logic [63:0] d,
                         input bit snoop, input logic [63:0] s_addr, input int hold, input int exp_lat);
        logic [63:0]      exp_data, exp_wd, old;
        bit               exp_err, exp_wr, exp_rd;
        int unsigned      rd0, wr0;
        int               lat;
        logic [TAG_W-1:0] tag;
        tag      = TAG_W'($urandom);
        exp_err  = (a[2:0] != 3'd0) || f[2] || (!LRSC && f[1]);
        exp_wr   = 1'b0; exp_rd = 1'b0; exp_data = '0; exp_wd = '0;
        if (snoop && resv_a == s_addr) resv_v = 1'b0;
        if (exp_err) begin
            if (f == 3'd3) resv_v = 1'b0;
        end else begin
            case (f)
                3'd0, 3'd1: begin
                    old = ref_rd(a); exp_rd = 1'b1; exp_wr = 1'b1; exp_data = old;
                    exp_wd = (f == 3'd0) ? old + d : d;
                    ref_mem[a] = exp_wd;
                    if (resv_a == a) resv_v = 1'b0;
                end
                3'd2: begin
                    exp_data = ref_rd(a); exp_rd = 1'b1; resv_v = 1'b1; resv_a = a;
                end
                default: begin
                    if (resv_v && resv_a == a) begin
                        exp_wr = 1'b1; exp_wd = d; ref_mem[a] = d; exp_data = '0;
                    end else exp_data = 64'd1;
                    resv_v = 1'b0;
                end
            endcase
        end

        check_eq("idle_ready", 64'(req_ready_o), 64'd1);
        rd0 = n_rd; wr0 = n_wr; wr_q.delete();
        req_valid_i = 1'b1; req_addr_i = a; req_data_i = d; req_funct_i = f; req_tag_i = tag;
        snoop_valid_i = snoop; snoop_addr_i = s_addr;
        @(negedge clk);
        req_valid_i = 1'b0; snoop_valid_i = 1'b0;
        lat = 1;
        while (!resp_valid_o && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check_eq("resp_seen", 64'(resp_valid_o), 64'd1);
        if (exp_lat > 0) check_eq("latency", 64'(lat), 64'(exp_lat));
        check_eq("resp_data", resp_data_o, exp_data);
        check_eq("resp_err", 64'(resp_err_o), 64'(exp_err));
        check_eq("resp_tag", 64'(resp_tag_o), 64'(tag));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_eq("hold_valid", 64'(resp_valid_o), 64'd1);
            check_eq("hold_data", resp_data_o, exp_data);
            check_eq("hold_tag", 64'(resp_tag_o), 64'(tag));
            check_eq("hold_busy", 64'(req_ready_o), 64'd0);
        end
        resp_ready_i = 1'b1;
        @(negedge clk);
        resp_ready_i = 1'b0;
        check_eq("back_idle", 64'(req_ready_o), 64'd1);
        check_eq("n_rd", 64'(n_rd - rd0), 64'(exp_rd));
        check_eq("n_wr", 64'(n_wr - wr0), 64'(exp_wr));
        if (exp_wr && wr_q.size() > 0) begin
            check_eq("wr_addr", wr_q[0][127:64], a);
            check_eq("wr_data", wr_q[0][63:0], exp_wd);
        end
    endtask

    task automatic snoop_idle(input logic [63:0] sa);
        snoop_valid_i = 1'b1; snoop_addr_i = sa;
        @(negedge clk);
        snoop_valid_i = 1'b0;
        if (resv_a == sa) resv_v = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  f;
        logic [63:0] a, d, sa, last_lr;
        int unsigned r;
        rst_n = 1'b0; req_valid_i = 1'b0; req_addr_i = '0; req_data_i = '0; req_funct_i = '0;
        req_tag_i = '0; snoop_valid_i = 1'b0; snoop_addr_i = '0; resp_ready_i = 1'b0;
        last_lr = 64'h200;
        repeat (2) @(negedge clk);
        check_eq("rst_ready", 64'(req_ready_o), 64'd1);
        check_eq("rst_outs", outs_or(), 64'd0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_outs", outs_or(), 64'd0);

        mem[64'h100] = 64'd5; ref_mem[64'h100] = 64'd5;
        do_op(3'd0, 64'h100, 64'd7, 1'b0, '0, 0, 6);
        check_eq("add_mem", env_rd(64'h100), 64'd12);

        mem[64'h108] = 64'hAA; ref_mem[64'h108] = 64'hAA;
        gnt_lo = 3; gnt_hi = 3;
        do_op(3'd1, 64'h108, 64'h55, 1'b0, '0, 0, -1);
        check_eq("swap_mem", env_rd(64'h108), 64'h55);
        gnt_lo = 0; gnt_hi = 0;

        do_op(3'd0, 64'h104, 64'd1, 1'b0, '0, 0, 1);
        do_op(3'd5, 64'h100, 64'd1, 1'b0, '0, 0, 1);

        do_op(3'd2, 64'h200, 64'd0, 1'b0, '0, 0, -1);
        do_op(3'd3, 64'h200, 64'd9, 1'b0, '0, 0, -1);
        do_op(3'd3, 64'h200, 64'd9, 1'b0, '0, 0, -1);
        do_op(3'd2, 64'h200, 64'd0, 1'b0, '0, 0, -1);
        do_op(3'd3, 64'h200, 64'd9, 1'b1, 64'h200, 0, -1);

        do_op(3'd0, 64'h110, 64'd3, 1'b0, '0, 4, 6);

        // Abort an AMO in RD_WAIT; its late read data arrives while idle.
        do_op(3'd2, 64'h200, 64'd0, 1'b0, '0, 0, -1);
        rv_lo = 3; rv_hi = 3;
        req_valid_i = 1'b1; req_addr_i = 64'h118; req_data_i = 64'd4; req_funct_i = 3'd0;
        req_tag_i = 6'h2A;
        @(negedge clk);
        req_valid_i = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("abort_ready", 64'(req_ready_o), 64'd1);
        check_eq("abort_outs", outs_or(), 64'd0);
        resv_v = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("abort_quiet", outs_or(), 64'd0);
            check_eq("abort_idle", 64'(req_ready_o), 64'd1);
        end
        rv_lo = 0; rv_hi = 0;
        do_op(3'd3, 64'h200, 64'd6, 1'b0, '0, 0, -1);
        do_op(3'd0, 64'h118, 64'd4, 1'b0, '0, 0, 6);

        gnt_hi = 2; rv_hi = 2; amo_hi = 2;
        for (int k = 0; k < 150; k++) begin
            r = $urandom_range(9, 0);
            f = (r < 3) ? 3'd0 : (r < 5) ? 3'd1 : (r < 7) ? 3'd2 : (r < 9) ? 3'd3
                                         : 3'($urandom_range(7, 4));
            a = 64'h100 + 64'(8 * $urandom_range(7, 0));
            if (f == 3'd3 && $urandom_range(2, 0) != 0) a = last_lr;
            if (f == 3'd2) last_lr = a;
            if ($urandom_range(9, 0) == 0) a = a + 64'($urandom_range(7, 1));
            d  = {$urandom, $urandom};
            sa = $urandom_range(1, 0) ? {a[63:3], 3'b000} : 64'h100 + 64'(8 * $urandom_range(7, 0));
            if ($urandom_range(7, 0) == 0) snoop_idle(sa);
            do_op(f, a, d, $urandom_range(5, 0) == 0, sa, int'($urandom_range(2, 0)), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/amo_seq_ctrl.md
# amo_seq_ctrl

Sequencer for RV64A atomic memory operations. Takes one AMO from the issue stage and runs a read-modify-write over the LSU memory port, using the single-cycle AMO arithmetic unit for the modify step. Returns the old memory value, or the SC status, to writeback. Sits between the issue/commit logic, the AMO arithmetic unit and the LSU data-cache port.

## Interface
- TAG_W, 6, width of the writeback tag carried with each request
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid_i / req_ready_o  in/out  1  request handshake; ready is high only in IDLE
- req_addr_i  in  64  doubleword address
- req_data_i  in  64  rs2 operand
- req_funct_i  in  3  0=AMOADD.D, 1=AMOSWAP.D, 2=LR.D, 3=SC.D
- req_tag_i  in  TAG_W  writeback tag
- mem_req_o, mem_we_o  out  1  memory request and write enable
- mem_addr_o, mem_wdata_o  out  64  memory address and store data
- mem_gnt_i, mem_rvalid_i  in  1  request grant; read data valid
- mem_rdata_i  in  64  read data
- amo_valid_o  out  1  one-cycle start pulse to the AMO unit
- amo_op_a_o, amo_op_b_o  out  64  loaded value; rs2
- amo_funct_o  out  3  function code to the AMO unit
- amo_ready_i  in  1  AMO unit result valid
- amo_result_i  in  64  AMO unit result
- snoop_valid_i  in  1  external store or invalidate seen
- snoop_addr_i  in  64  address of that store or invalidate
- resp_valid_o / resp_ready_i  out/in  1  response handshake
- resp_data_o  out  64  old memory value, or SC status
- resp_tag_o  out  TAG_W  tag of the request
- resp_err_o  out  1  misaligned address or illegal funct

## Operation
- States: IDLE, RD_REQ, RD_WAIT, EXEC, EXEC_WAIT, WR_REQ, RESP.
- On acceptance, capture addr, data, funct and tag.
- Error check at acceptance: addr[2:0]!=0, or an illegal funct (4-7, or 2/3 when LR/SC is compiled out).
  - On error, go straight to RESP with resp_err_o=1 and resp_data_o=0.
  - No memory access is made.
- AMOADD/AMOSWAP path: RD_REQ → RD_WAIT → EXEC → EXEC_WAIT → WR_REQ → RESP.
  - Old value is captured on mem_rvalid_i and returned in resp_data_o.
  - mem_wdata_o is amo_result_i, latched in EXEC_WAIT.
- RD_REQ and WR_REQ hold mem_req_o and its address/data stable until mem_gnt_i. Writes have no completion.
- Only one operation is in flight; req_ready_o=0 outside IDLE.
- Reset mid-operation returns to IDLE immediately.
  - Outstanding mem_rvalid_i is ignored while in IDLE.
  - Reservation is cleared.

## Timing
- Reset values: all outputs 0 except req_ready_o=1 (IDLE); state=IDLE; reservation invalid.
- Cycle accounting, with mem_gnt_i the same cycle and rvalid one cycle after grant:
  - t0 accept; t1 RD_REQ; t2 RD_WAIT, rvalid; t3 EXEC with amo_valid_o; t4 EXEC_WAIT with amo_ready_i; t5 WR_REQ, gnt; t6 resp_valid_o.
  - Minimum AMO latency is 6 cycles.
- Error response: resp_valid_o at t1.
- RESP holds resp_* stable until resp_ready_i. The state returns to IDLE the cycle after the handshake.
- Back-to-back: the next request can be accepted the cycle after the response handshake.

## Configuration
- AMO_LRSC_EN defined: funct 2/3 are supported, with a single reservation register (valid plus 64-bit address).
  - LR.D: read path only, skipping EXEC and WR_REQ. Sets the reservation to addr and returns the loaded value.
  - SC.D success (reservation valid and address match): skip the read; WR_REQ with rs2; respond 0; clear the reservation.
  - SC.D failure: no memory access; respond 1.
  - The reservation is cleared by:
    - any SC;
    - any AMO write grant to the reserved address;
    - snoop_valid_i with a matching address.
  - Snoop in the same cycle as the SC check: the snoop wins and the SC fails.
  - Snoop in the same cycle as the LR rvalid: the LR sets the reservation and the snoop is ignored.
- AMO_LRSC_EN undefined: no reservation logic; funct 2/3 produce an error response; snoop inputs are unused.

## Structure
- Shared package amo_pkg holds:
  - amo_funct_e enum (ADD=0, SWAP=1, LR=2, SC=3);
  - amo_state_e state enum;
  - SC_FAIL=64'd1 constant.
- One sub-module: amo_resv_tracker (reservation register, match and clear logic), instantiated only under AMO_LRSC_EN.

## Test plan
- AMOADD, mem[0x100]=5, rs2=7, zero-wait memory: resp_data=5 at t6; write of 12 to 0x100.
- AMOSWAP, mem[0x108]=0xAA, rs2=0x55, gnt delayed 3 cycles: resp_data=0xAA; write of 0x55; req/addr held stable while waiting.
- Misaligned addr 0x104: no mem_req_o; resp_err_o=1 at t1; resp_data=0.
- (LRSC) LR 0x200 then SC 0x200 with rs2=9: SC responds 0 and 9 is written. A second SC responds 1 with no write.
- (LRSC) LR 0x200, snoop 0x200 during the SC check cycle, then SC: responds 1, no write.
- resp_ready_i held low 4 cycles: outputs stable, req_ready_o=0. Reset during RD_WAIT: all outputs return to reset values.
